clock_divider: RTL and testbench



---
 rtl/clock_divider.sv | 70 +++++++
 tb/tb_clock_divider.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/clock_divider.sv
// ---------------------------------------------------------------------------
// clock_divider
//
// Divides clock_in by a fixed even ratio DIVIDE (a multiple of 4, >= 4) and
// produces two 50%-duty square waves in quadrature.
//
// Ports:
//   clock_in      in   sole clock; all state updates on its rising edge
//   reset         in   asynchronous, active-high reset
//   clock_div4_0  out  divided clock, 0 deg phase, 50% duty
//   clock_div4_90 out  divided clock lagging clock_div4_0 by DIVIDE/4
//                      input cycles (90 deg), 50% duty
//
// Both outputs come straight from flip-flops, so they are glitch-free.
// Reset release must already be synchronous to clock_in; there is no
// internal reset synchronizer.
// ---------------------------------------------------------------------------
module clock_divider #(
  parameter int DIVIDE = 4
) (
  input  logic clock_in,
  input  logic reset,
  output logic clock_div4_0,
  output logic clock_div4_90
);

  localparam int W = (DIVIDE > 1) ? $clog2(DIVIDE) : 1;

  localparam logic [W-1:0] LAST    = W'(DIVIDE - 1);
  localparam logic [W-1:0] HALF    = W'(DIVIDE / 2);
  localparam logic [W-1:0] QUARTER = W'(DIVIDE / 4);
  localparam logic [W-1:0] THREE_Q = W'((3 * DIVIDE) / 4);
  localparam logic [W-1:0] ONE     = W'(1);

  generate
    if ((DIVIDE < 4) || ((DIVIDE % 4) != 0)) begin : g_bad_divide
      $error("clock_divider: DIVIDE must be a multiple of 4 and >= 4");
    end
  endgenerate

  // cnt holds the phase p that the *next* rising edge will produce; the
  // outputs are registered from it, so after edge k they reflect
  // p = (k-1) mod DIVIDE.
  logic [W-1:0] cnt;
  logic [W-1:0] cnt_next;
  logic         div0_next;
  logic         div90_next;

  always_comb begin
    cnt_next   = (cnt == LAST) ? '0 : cnt + ONE;
    div0_next  = (cnt < HALF);
    // ((p - DIVIDE/4) mod DIVIDE) < DIVIDE/2 reduces to the window
    // DIVIDE/4 <= p < 3*DIVIDE/4. This also keeps the lagging output low
    // for the first DIVIDE/4 edges after reset, with no extra start flag.
    div90_next = (cnt >= QUARTER) && (cnt < THREE_Q);
  end

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      cnt           <= '0;
      clock_div4_0  <= 1'b0;
      clock_div4_90 <= 1'b0;
    end else begin
      cnt           <= cnt_next;
      clock_div4_0  <= div0_next;
      clock_div4_90 <= div90_next;
    end
  end

endmodule

// File: tb/tb_clock_divider.sv
`timescale 1ns/1ps
module tb_clock_divider;

  logic clock_in;
  logic reset;
  logic d4_0, d4_90, d8_0, d8_90;

  int compared   = 0;
  int mismatched = 0;
  int k          = 0;   // rising edges since reset release
  bit timing_en  = 1'b0;

  typedef struct packed {
    logic e4_0;
    logic e4_90;
    logic e8_0;
    logic e8_90;
  } exp_t;

  exp_t sb_q[$];
  exp_t cur;

  clock_divider #(.DIVIDE(4)) u_div4 (
    .clock_in      (clock_in),
    .reset         (reset),
    .clock_div4_0  (d4_0),
    .clock_div4_90 (d4_90)
  );

  clock_divider #(.DIVIDE(8)) u_div8 (
    .clock_in      (clock_in),
    .reset         (reset),
    .clock_div4_0  (d8_0),
    .clock_div4_90 (d8_90)
  );

  initial clock_in = 1'b0;
  always #2.5 clock_in = ~clock_in;

  task automatic check(input string tag, input logic obs, input logic exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0b expected %0b (k=%0d t=%0t)", tag, obs, exp, k, $time);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    compared++;
    assert (obs == exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model from the behavioural definition.
  function automatic logic model_0(input int kk, input int d);
    int p;
    p = (kk - 1) % d;
    return (p < d / 2);
  endfunction

  function automatic logic model_90(input int kk, input int d);
    int p;
    p = (kk - 1) % d;
    return (kk > d / 4) && ((((p - d / 4) % d + d) % d) < d / 2);
  endfunction

  // Drive n edges: push expectation, wait for edge, pop and compare;
  // then re-check at the falling edge that nothing moved.
  task automatic run_edges(input int n, input bit verbose);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      k++;
      e.e4_0  = model_0(k, 4);
      e.e4_90 = model_90(k, 4);
      e.e8_0  = model_0(k, 8);
      e.e8_90 = model_90(k, 8);
      sb_q.push_back(e);
      @(posedge clock_in);
      #1;
      cur = sb_q.pop_front();
      check("d4_0", d4_0, cur.e4_0);
      check("d4_90", d4_90, cur.e4_90);
      check("d8_0", d8_0, cur.e8_0);
      check("d8_90", d8_90, cur.e8_90);
      if (verbose)
        $display("edge k=%0d d4=%0b%0b d8=%0b%0b exp d4=%0b%0b d8=%0b%0b", k,
                 d4_0, d4_90, d8_0, d8_90, cur.e4_0, cur.e4_90, cur.e8_0, cur.e8_90);
      @(negedge clock_in);
      #0.1;
      check("neg_d4_0", d4_0, cur.e4_0);
      check("neg_d4_90", d4_90, cur.e4_90);
      check("neg_d8_0", d8_0, cur.e8_0);
      check("neg_d8_90", d8_90, cur.e8_90);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_d4_0"}, d4_0, 1'b0);
    check({tag, "_d4_90"}, d4_90, 1'b0);
    check({tag, "_d8_0"}, d8_0, 1'b0);
    check({tag, "_d8_90"}, d8_90, 1'b0);
  endtask

  // Waveform timing on the DIVIDE=4 outputs during the long run.
  realtime t0_rise = -1.0, t90_rise = -1.0;
  always @(posedge d4_0) if (timing_en && !reset) begin
    if (t0_rise >= 0.0) check_int("period_d4_0_ps", int'((($realtime - t0_rise) * 1000.0)), 20000);
    t0_rise = $realtime;
  end
  always @(negedge d4_0) if (timing_en && !reset && t0_rise >= 0.0)
    check_int("high_d4_0_ps", int'((($realtime - t0_rise) * 1000.0)), 10000);
  always @(posedge d4_90) if (timing_en && !reset) begin
    if (t0_rise >= 0.0) check_int("lag_d4_90_ps", int'((($realtime - t0_rise) * 1000.0)), 5000);
    if (t90_rise >= 0.0) check_int("period_d4_90_ps", int'((($realtime - t90_rise) * 1000.0)), 20000);
    t90_rise = $realtime;
  end
  always @(negedge d4_90) if (timing_en && !reset && t90_rise >= 0.0)
    check_int("high_d4_90_ps", int'((($realtime - t90_rise) * 1000.0)), 10000);

  initial begin
    int guard;
    // Power-up reset for 3 cycles.
    reset = 1'b1;
    #0.5;
    check_reset_state("por_async");
    for (int i = 0; i < 3; i++) begin
      @(posedge clock_in);
      #1;
      check_reset_state("por_hold");
    end
    @(negedge clock_in);
    reset = 1'b0;
    k = 0;

    // First 16 edges: DIVIDE=4 pattern twice per 8 edges, DIVIDE=8 full cycles.
    run_edges(16, 1'b1);

    // Long run (~1000 ns) with waveform timing checks.
    timing_en = 1'b1;
    run_edges(200, 1'b0);
    timing_en = 1'b0;
    $display("long run done k=%0d", k);

    // Advance to a phase where both DIVIDE=4 outputs are high (p == 1).
    guard = 0;
    while (((k - 1) % 4) != 1 && guard < 8) begin
      run_edges(1, 1'b0);
      guard++;
    end
    check("pre_reset_d4_0", d4_0, 1'b1);
    check("pre_reset_d4_90", d4_90, 1'b1);

    // Asynchronous reset between edges: outputs must drop without an edge.
    #0.5;
    reset = 1'b1;
    #0.1;
    check_reset_state("async_rst");
    $display("async reset at t=%0t d4=%0b%0b d8=%0b%0b", $time, d4_0, d4_90, d8_0, d8_90);

    // Hold reset for 20 cycles with the clock running.
    for (int i = 0; i < 20; i++) begin
      @(posedge clock_in);
      #1;
      check_reset_state("rst_hold");
      check_int("rst_hold_cnt4", int'(u_div4.cnt), 0);
      check_int("rst_hold_cnt8", int'(u_div8.cnt), 0);
    end
    @(negedge clock_in);
    reset = 1'b0;
    k = 0;

    // Sequence must restart from k=1.
    run_edges(16, 1'b1);

    check_int("sb_queue_empty", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Absolute time bound so the run can never hang.
  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish, observed t=%0t required < 50000 ns", $time);
    $fatal(1, "timeout");
  end

endmodule
